// File: rtl/sodor5_gen_pkg.sv
// Shared constants, enums and the LFSR step function for the
// sodor5 constrained-random RV32I instruction source.
package sodor5_gen_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] SEED_XOR   = 32'hA5A5_A5A5;

    typedef enum logic [1:0] {
        KIND_NOP   = 2'd0,
        KIND_ALUI  = 2'd1,
        KIND_LOAD  = 2'd2,
        KIND_STORE = 2'd3
    } kind_e;

    typedef enum logic {
        S_NOP = 1'b0,
        S_GEN = 1'b1
    } state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/gen_lfsr32.sv
// 32-bit Galois LFSR with a parameterised seed. An all-zero seed would
// lock the register up, so it is replaced by 32'h1.
module gen_lfsr32
    import sodor5_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_step,
    output logic [31:0] o_state
);

    localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    logic [31:0] r_state;

    // State register: load the seed on reset, advance only when asked.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values,
        // independent of the order in which always blocks are evaluated.
        if (reset) begin
            r_state <= INIT;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/sodor5_ils_instr_gen.sv
// Constrained-random RV32I instruction source (OP-IMM, LB/LBU, SB) with a
// registered valid/ready output and optional rs1 RAW-hazard injection.
// A fixed number of NOP beats precede random generation after reset.
module sodor5_ils_instr_gen
    import sodor5_gen_pkg::*;
#(
    parameter logic [31:0] SEED       = 32'h0000_004D,
    parameter int          NOP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        hazard_en,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [1:0]  instr_kind,
    output logic [31:0] gen_count
);

    // Counter is just wide enough to reach NOP_CYCLES (at least one bit).
    localparam int               CNT_W     = $clog2(NOP_CYCLES + 2);
    localparam logic [CNT_W-1:0] NOP_LIMIT = CNT_W'(NOP_CYCLES);

    // ---------------------------------------------------------------- state
    state_e           r_state;
    logic [CNT_W-1:0] r_nop_cnt;
    logic [31:0]      r_instr;
    logic             r_valid;
    kind_e            r_kind;
    logic [31:0]      r_gen_count;
    logic [4:0]       r_last_rd;
    logic             r_last_rd_vld;

    // ---------------------------------------------------------------- wires
    logic [31:0]      w_lfsr_a;
    logic [31:0]      w_lfsr_b;
    logic             w_accept;
    logic             w_reload;
    logic             w_step;
    logic             w_do_gen;
    logic             w_unused;

    logic [11:0]      w_imm;
    logic [11:0]      w_imm_l;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic [2:0]       w_f3;
    logic [2:0]       w_f3l;
    logic [1:0]       w_choice;
    logic             w_coin;
    logic [31:0]      w_enc_instr;
    kind_e            w_enc_kind;
    logic             w_enc_has_rd;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_nop_cnt_nxt;
    logic [31:0]      w_instr_nxt;
    logic             w_valid_nxt;
    kind_e            w_kind_nxt;
    logic [4:0]       w_last_rd_nxt;
    logic             w_last_rd_vld_nxt;

    // A held beat (valid && !ready) freezes everything, including the LFSRs.
    assign w_accept = r_valid & instr_ready;
    assign w_reload = ~r_valid | instr_ready;

    // LFSR bits that no field slice consumes.
    assign w_unused = &{1'b0, w_lfsr_a[31:30], w_lfsr_b[30:17]};

    gen_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr_a (
        .clk     (clk),
        .reset   (reset),
        .i_step  (w_step),
        .o_state (w_lfsr_a)
    );

    gen_lfsr32 #(
        .SEED (SEED ^ SEED_XOR)
    ) u_lfsr_b (
        .clk     (clk),
        .reset   (reset),
        .i_step  (w_step),
        .o_state (w_lfsr_b)
    );

    // Field slicing, hazard substitution and encoding of the candidate beat.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an uncovered path would infer a latch.
        w_imm        = w_lfsr_a[11:0];
        w_rs1        = w_lfsr_a[16:12];
        w_rd         = w_lfsr_a[21:17];
        w_f3         = w_lfsr_a[24:22];
        w_f3l        = w_lfsr_a[27:25] & 3'b100;
        w_choice     = w_lfsr_a[29:28];
        w_imm_l      = w_lfsr_b[11:0];
        w_rs2        = w_lfsr_b[16:12];
        w_coin       = w_lfsr_b[31];
        w_enc_instr  = INSTR_NOP;
        w_enc_kind   = KIND_NOP;
        w_enc_has_rd = 1'b0;

        // Reuse the last written register as rs1; x0 would not be a hazard.
        if (hazard_en && w_coin && r_last_rd_vld && (r_last_rd != 5'd0)) begin
            w_rs1 = r_last_rd;
        end

        // Shifts only take a 5-bit shamt; SRAI additionally keeps imm[10].
        case (w_f3)
            3'd5:    w_imm = w_imm & 12'h41F;
            3'd1:    w_imm = w_imm & 12'h01F;
            default: w_imm = w_imm;
        endcase

        if (w_choice[1]) begin
            w_enc_instr  = {w_imm, w_rs1, w_f3, w_rd, OPC_OP_IMM};
            w_enc_kind   = KIND_ALUI;
            w_enc_has_rd = 1'b1;
        end else if (w_choice[0]) begin
            w_enc_instr  = {w_imm_l[11:5], w_rs2, w_rs1, 3'b000, w_imm_l[4:0], OPC_STORE};
            w_enc_kind   = KIND_STORE;
        end else begin
            // f3l is LB (000) or LBU (100).
            w_enc_instr  = {w_imm_l, w_rs1, w_f3l, w_rd, OPC_LOAD};
            w_enc_kind   = KIND_LOAD;
            w_enc_has_rd = 1'b1;
        end
    end

    // Next-state and output-register load decisions.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt             = r_nop_cnt;
        w_nop_cnt_nxt     = r_nop_cnt;
        w_instr_nxt       = r_instr;
        w_valid_nxt       = r_valid;
        w_kind_nxt        = r_kind;
        w_last_rd_nxt     = r_last_rd;
        w_last_rd_vld_nxt = r_last_rd_vld;
        w_do_gen          = 1'b0;
        w_step            = 1'b0;

        if (w_reload) begin
            case (r_state)
                S_NOP: begin
                    if (w_accept) begin
                        w_cnt = r_nop_cnt + CNT_W'(1);
                    end
                    w_nop_cnt_nxt = w_cnt;
                    if (w_cnt == NOP_LIMIT) begin
                        w_state_nxt = S_GEN;
                        w_do_gen    = 1'b1;
                    end else begin
                        w_instr_nxt = INSTR_NOP;
                        w_valid_nxt = 1'b1;
                        w_kind_nxt  = KIND_NOP;
                    end
                end
                S_GEN: begin
                    w_do_gen = 1'b1;
                end
                default: begin
                    w_state_nxt = S_NOP;
                end
            endcase
        end

        if (w_do_gen) begin
            if (enable) begin
                w_instr_nxt = w_enc_instr;
                w_valid_nxt = 1'b1;
                w_kind_nxt  = w_enc_kind;
                w_step      = 1'b1;
                if (w_enc_has_rd) begin
                    w_last_rd_nxt     = w_rd;
                    w_last_rd_vld_nxt = 1'b1;
                end
            end else begin
                w_instr_nxt = INSTR_NOP;
                w_valid_nxt = 1'b0;
                w_kind_nxt  = KIND_NOP;
            end
        end
    end

    // FSM, NOP counter, output beat and hazard-tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_NOP;
            r_nop_cnt     <= '0;
            r_instr       <= INSTR_NOP;
            r_valid       <= 1'b0;
            r_kind        <= KIND_NOP;
            r_last_rd     <= 5'd0;
            r_last_rd_vld <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_nop_cnt     <= w_nop_cnt_nxt;
            r_instr       <= w_instr_nxt;
            r_valid       <= w_valid_nxt;
            r_kind        <= w_kind_nxt;
            r_last_rd     <= w_last_rd_nxt;
            r_last_rd_vld <= w_last_rd_vld_nxt;
        end
    end

    // Count accepted random beats; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen_count <= 32'd0;
        end else if (w_accept && (r_kind != KIND_NOP)) begin
            r_gen_count <= r_gen_count + 32'd1;
        end
    end

    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_kind  = r_kind;
    assign gen_count   = r_gen_count;

endmodule
